rf_write_port_arbiter: RTL and testbench

- Shares the register file's single write port between two sources: pipeline writeback (WB) and a long-latency unit (LL, e.g. mul/div), which uses a valid/ready handshake.
- LL results are buffered in a small FIFO and drain into idle write slots.
- A 32-entry scoreboard tracks registers with LL results still pending. It produces a decode stall on RAW and WAW hazards.
- Sits between the WB stage, the LL unit and the register file's WE3/A3/WD3 inputs.

---
 rtl/rf_ctrl_pkg.sv | 19 +
 rtl/rf_ll_fifo.sv | 52 +++++
 rtl/rf_write_port_arbiter.sv | 125 ++++++++++++
 tb/tb_rf_write_port_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared types for the register-file write-port control slice.
// Used by rf_ll_fifo and rf_write_port_arbiter (optional build macro RF_ARB_LL_BYPASS_EN).
package rf_ctrl_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } rf_wr_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WB_WRITE = 2'd1,
    LL_WRITE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rf_ll_fifo.sv
// Synchronous FIFO of pending long-latency register writes.
// Pointers carry one extra wrap bit so full and empty need no separate counter.
module rf_ll_fifo
  import rf_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  rf_wr_t wr_data,
  input  logic   pop,
  output rf_wr_t rd_data,
  output logic   full,
  output logic   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  rf_wr_t      mem_q [DEPTH];

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push && !full)  wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop  && !empty) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // NOTE: state uses non-blocking assignments and a synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; resetting the pointers alone makes every entry invalid.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/rf_write_port_arbiter.sv
// Arbitrates the single register-file write port between WB and buffered LL results,
// with a busy scoreboard for decode hazards. Define RF_ARB_LL_BYPASS_EN for LL bypass.
module rf_write_port_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int LL_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [REG_AW-1:0] ll_rd,
  input  logic [XLEN-1:0]   ll_data,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] dec_rs1,
  input  logic [REG_AW-1:0] dec_rs2,
  input  logic [REG_AW-1:0] dec_rd,
  output logic              hazard_stall,
  output logic              starve_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_a3,
  output logic [XLEN-1:0]   rf_wd3
);

  localparam int              CW         = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0]   STARVE_LIM = CW'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  logic [REG_AW-1:0] rf_a3_q, rf_a3_d;
  logic [XLEN-1:0]   rf_wd3_q, rf_wd3_d;
  logic [CW-1:0]     starve_q, starve_d;
  logic              starve_stall_q, starve_stall_d;
  logic [31:0]       busy_q, busy_d;

  logic   wb_valid, ll_hs, bypass;
  logic   fifo_push, fifo_pop, fifo_full, fifo_empty;
  rf_wr_t fifo_head, ll_in;

  assign wb_valid = wb_we && (wb_rd != '0);
  assign ll_ready = !fifo_full;
  assign ll_hs    = ll_valid && ll_ready;
  assign ll_in    = '{rd: ll_rd, data: ll_data};

  rf_ll_fifo #(.DEPTH(LL_DEPTH)) u_ll_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (ll_in),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    state_d  = IDLE;
    rf_a3_d  = rf_a3_q;
    rf_wd3_d = rf_wd3_q;
    fifo_pop = 1'b0;
    bypass   = 1'b0;
    busy_d   = busy_q;
    starve_d = starve_q;
`ifdef RF_ARB_LL_BYPASS_EN
    bypass = ll_hs && (ll_rd != '0) && !wb_valid && fifo_empty;
`endif
    // LL results for x0 are acknowledged but never stored or written.
    fifo_push = ll_hs && (ll_rd != '0) && !bypass;

    if (wb_valid) begin
      state_d  = WB_WRITE;
      rf_a3_d  = wb_rd;
      rf_wd3_d = wb_data;
    end else if (!fifo_empty) begin
      fifo_pop              = 1'b1;
      state_d               = LL_WRITE;
      rf_a3_d               = fifo_head.rd;
      rf_wd3_d              = fifo_head.data;
      busy_d[fifo_head.rd]  = 1'b0;
    end else if (bypass) begin
      state_d        = LL_WRITE;
      rf_a3_d        = ll_rd;
      rf_wd3_d       = ll_data;
      busy_d[ll_rd]  = 1'b0;
    end

    if (fifo_empty || fifo_pop)                  starve_d = '0;
    else if (wb_valid && starve_q != STARVE_LIM) starve_d = starve_q + 1'b1;
    starve_stall_d = (starve_d == STARVE_LIM);

    // Issue is applied after the clear so a same-cycle set wins.
    if (iss_valid && iss_rd != '0) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= IDLE;
      rf_a3_q        <= '0;
      rf_wd3_q       <= '0;
      starve_q       <= '0;
      starve_stall_q <= 1'b0;
      busy_q         <= '0;
    end else begin
      state_q        <= state_d;
      rf_a3_q        <= rf_a3_d;
      rf_wd3_q       <= rf_wd3_d;
      starve_q       <= starve_d;
      starve_stall_q <= starve_stall_d;
      busy_q         <= busy_d;
    end
  end

  assign rf_we        = (state_q != IDLE);
  assign rf_a3        = rf_a3_q;
  assign rf_wd3       = rf_wd3_q;
  assign starve_stall = starve_stall_q;
  assign hazard_stall = busy_q[dec_rs1] | busy_q[dec_rs2] | busy_q[dec_rd];

endmodule

// File: tb/tb_rf_write_port_arbiter.sv
// Self-checking bench for rf_write_port_arbiter: a reference model pushes the expected
// rf_* outcome of every cycle onto a queue, popped and compared after the clock edge.
module tb_rf_write_port_arbiter;
  import rf_ctrl_pkg::*;

  localparam int LL_DEPTH   = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we, ll_valid, ll_ready, iss_valid;
  logic [4:0]  wb_rd, ll_rd, iss_rd, dec_rs1, dec_rs2, dec_rd;
  logic [31:0] wb_data, ll_data;
  logic        hazard_stall, starve_stall, rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;

  rf_write_port_arbiter #(.LL_DEPTH(LL_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
    .hazard_stall(hazard_stall), .starve_stall(starve_stall),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic        starve;
  } exp_t;

  exp_t        exp_q[$];
  rf_wr_t      m_fifo[$];
  logic [31:0] m_busy;
  int          m_cnt;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    wb_we = 0; wb_rd = 0; wb_data = 0;
    ll_valid = 0; ll_rd = 0; ll_data = 0;
    iss_valid = 0; iss_rd = 0;
  endtask

  // One clock cycle: check combinational outputs, advance the model, check registered outputs.
  task automatic tick();
    exp_t   e;
    rf_wr_t head;
    logic   wbv, full, hs, byp, pop;
    int     size0;
    #1;
    size0 = m_fifo.size();
    full  = (size0 == LL_DEPTH);
    e     = '{we: 1'b0, a3: 5'd0, wd: 32'd0, starve: 1'b0};
    if (!rst) begin
      m_fifo.delete();
      m_busy = '0; m_cnt = 0; m_a3 = '0; m_wd = '0;
    end else begin
      check("ll_ready", {31'd0, ll_ready}, {31'd0, !full});
      check("hazard_stall", {31'd0, hazard_stall},
            {31'd0, m_busy[dec_rs1] | m_busy[dec_rs2] | m_busy[dec_rd]});
      wbv = wb_we && (wb_rd != 0);
      hs  = ll_valid && !full;
      byp = 1'b0;
`ifdef RF_ARB_LL_BYPASS_EN
      byp = hs && (ll_rd != 0) && !wbv && (size0 == 0);
`endif
      pop = !wbv && (size0 != 0);
      if (wbv) begin
        e.we = 1; m_a3 = wb_rd; m_wd = wb_data;
      end else if (pop) begin
        head = m_fifo.pop_front();
        e.we = 1; m_a3 = head.rd; m_wd = head.data; m_busy[head.rd] = 1'b0;
      end else if (byp) begin
        e.we = 1; m_a3 = ll_rd; m_wd = ll_data; m_busy[ll_rd] = 1'b0;
      end
      if (size0 == 0 || pop)               m_cnt = 0;
      else if (wbv && m_cnt < STARVE_MAX)  m_cnt++;
      if (hs && ll_rd != 0 && !byp) m_fifo.push_back('{rd: ll_rd, data: ll_data});
      if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
      e.starve = (m_cnt == STARVE_MAX);
    end
    e.a3 = m_a3;
    e.wd = m_wd;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("rf_we",        {31'd0, rf_we},        {31'd0, e.we});
    check("rf_a3",        {27'd0, rf_a3},        {27'd0, e.a3});
    check("rf_wd3",       rf_wd3,                e.wd);
    check("starve_stall", {31'd0, starve_stall}, {31'd0, e.starve});
  endtask

  initial begin
    int lat;
    int exp_lat;
    idle_inputs();
    dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0;
    rst = 0;
    tick(); tick();
    rst = 1;
    tick();
    check("reset_ll_ready", {31'd0, ll_ready}, 32'd1);
    check("reset_hazard",   {31'd0, hazard_stall}, 32'd0);

    // Plain WB write, then a WB to x0 which must not take the port.
    wb_we = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    tick();
    check("wb_a3_direct", {27'd0, rf_a3}, 32'd5);
    wb_rd = 0; wb_data = 32'h0BAD0BAD;
    tick();
    check("wb_x0_dropped", {31'd0, rf_we}, 32'd0);
    idle_inputs();

    // Scoreboard round trip on x7.
    iss_valid = 1; iss_rd = 7;
    tick();
    idle_inputs();
    dec_rs2 = 7;
    tick();
    check("hazard_rs2_busy", {31'd0, hazard_stall}, 32'd1);
    ll_valid = 1; ll_rd = 7; ll_data = 32'h1234;
    tick();
    idle_inputs();
    lat = 1;
    while (!rf_we && lat < 6) begin
      tick();
      lat++;
    end
`ifdef RF_ARB_LL_BYPASS_EN
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
    check("ll_latency", lat, exp_lat);
    check("ll_wd3", rf_wd3, 32'h1234);
    tick();
    check("hazard_cleared", {31'd0, hazard_stall}, 32'd0);
    dec_rs2 = 0;

    // Contention: WB every cycle while LL results arrive; a third result is refused.
    iss_valid = 1; iss_rd = 10;
    tick();
    iss_rd = 11;
    tick();
    iss_valid = 0;
    for (int i = 0; i < 8; i++) begin
      wb_we = 1; wb_rd = 5'(1 + i); wb_data = 32'hA000_0000 + i;
      ll_valid = (i < 3);
      ll_rd = 5'(10 + i); ll_data = 32'hC000_0000 + i;
      tick();
    end
    check("full_ll_ready", {31'd0, ll_ready}, 32'd0);
    check("starve_set",    {31'd0, starve_stall}, 32'd1);
    idle_inputs();
    dec_rs1 = 10;
    tick();
    check("drain_a3", {27'd0, rf_a3}, 32'd10);
    check("starve_clear", {31'd0, starve_stall}, 32'd0);

    // Refill to two entries under WB pressure, then reset mid-drain.
    wb_we = 1; wb_rd = 3; wb_data = 32'h5555_0000;
    ll_valid = 1; ll_rd = 13; ll_data = 32'h1313_1313;
    iss_valid = 1; iss_rd = 13;
    tick();
    idle_inputs();
    rst = 0;
    tick();
    rst = 1;
    dec_rs1 = 11; dec_rs2 = 13;
    tick(); tick(); tick();
    check("post_reset_no_write", {31'd0, rf_we}, 32'd0);
    check("post_reset_busy", {31'd0, hazard_stall}, 32'd0);

    // Random traffic, including occasional resets.
    for (int i = 0; i < 400; i++) begin
      wb_we     = ($urandom_range(0, 2) == 0);
      wb_rd     = 5'($urandom_range(0, 31));
      wb_data   = $urandom;
      ll_valid  = ($urandom_range(0, 1) == 0);
      ll_rd     = 5'($urandom_range(0, 31));
      ll_data   = $urandom;
      iss_valid = ($urandom_range(0, 3) == 0);
      iss_rd    = 5'($urandom_range(0, 31));
      dec_rs1   = 5'($urandom_range(0, 31));
      dec_rs2   = 5'($urandom_range(0, 31));
      dec_rd    = 5'($urandom_range(0, 31));
      rst       = ($urandom_range(0, 63) != 0);
      tick();
    end
    rst = 1;
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
